// File: rtl/ldtu_rx_word_aligner_if.sv
// ============================================================================
// ldtu_rx_word_aligner_if : raw-word input / aligned-word output bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface ldtu_rx_word_aligner_if #(
  parameter int NBITS = 32
);
  logic [NBITS-1:0] din;
  logic             din_valid;
  logic             resync;
  logic [NBITS-1:0] dout;
  logic             dout_valid;
  logic             dout_idle;
  logic             locked;
  logic [4:0]       shift;
  logic [7:0]       slip_cnt;

  modport master (
    output din, din_valid, resync,
    input  dout, dout_valid, dout_idle, locked, shift, slip_cnt
  );

  modport slave (
    input  din, din_valid, resync,
    output dout, dout_valid, dout_idle, locked, shift, slip_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ldtu_rx_word_aligner.sv
// ============================================================================
// ldtu_rx_word_aligner : finds the lock-pattern bit offset and emits aligned words
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ldtu_rx_word_aligner #(
  parameter int          NBITS        = 32,
  parameter logic [31:0] LOCK_PATTERN = 32'h35555555,
  parameter logic [31:0] IDLE_PATTERN = 32'h5A5A5A5A,
  parameter int          LOCK_COUNT   = 4,
  parameter int          SLIP_COUNT   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  ldtu_rx_word_aligner_if.slave  bus
);

  localparam logic [1:0] c_HUNT   = 2'd0;
  localparam logic [1:0] c_VERIFY = 2'd1;
  localparam logic [1:0] c_LOCKED = 2'd2;
  localparam logic [3:0] c_LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] c_SLIP_N = 4'(SLIP_COUNT);

  logic [1:0]         r_state;
  logic [NBITS-1:0]   r_prev;
  logic [3:0]         r_match_cnt;
  logic [3:0]         r_slip_run;
  logic [NBITS-1:0]   r_dout;
  logic               r_dout_valid;
  logic               r_dout_idle;
  logic               r_locked;
  logic [4:0]         r_shift;
  logic [7:0]         r_slip_cnt;

  logic [2*NBITS-1:0] w_comb;
  logic [2*NBITS-1:0] w_comb_sh;
  logic [NBITS-1:0]   w_win;
  logic [31:0]        w_match;
  logic               w_any;
  logic               w_hit;
  logic [4:0]         w_first;
  logic [7:0]         w_slip_inc;

  assign w_comb = {r_prev, bus.din};

  for (genvar k = 0; k < 32; k++) begin : g_win
    assign w_match[k] = (w_comb[2*NBITS-1-k -: NBITS] == LOCK_PATTERN);
  end

  // Lowest matching offset wins when several windows hold the pattern
  always_comb begin
    w_first = '0;
    for (int k = 31; k >= 0; k--) begin
      if (w_match[k]) w_first = 5'(k);
    end
  end

  assign w_any      = |w_match;
  assign w_hit      = w_match[r_shift];
  assign w_comb_sh  = w_comb << r_shift;
  assign w_win      = w_comb_sh[2*NBITS-1 -: NBITS];
  assign w_slip_inc = (r_slip_cnt == 8'hFF) ? r_slip_cnt : r_slip_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_HUNT;
      r_prev       <= '0;
      r_match_cnt  <= '0;
      r_slip_run   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_idle  <= 1'b0;
      r_locked     <= 1'b0;
      r_shift      <= '0;
      r_slip_cnt   <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      if (bus.din_valid) r_prev <= bus.din;

      if (bus.resync) begin
        if (r_state == c_LOCKED) r_slip_cnt <= w_slip_inc;
        r_state     <= c_HUNT;
        r_match_cnt <= '0;
        r_slip_run  <= '0;
        r_locked    <= 1'b0;
      end else if (bus.din_valid) begin
        case (r_state)
          c_HUNT: begin
            if (w_any) begin
              r_shift     <= w_first;
              r_match_cnt <= 4'd1;
              if (LOCK_COUNT == 1) begin
                r_state  <= c_LOCKED;
                r_locked <= 1'b1;
              end else begin
                r_state  <= c_VERIFY;
              end
            end
          end
          c_VERIFY: begin
            if (w_hit) begin
              r_match_cnt <= r_match_cnt + 4'd1;
              if (r_match_cnt + 4'd1 == c_LOCK_N) begin
                r_state  <= c_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_match_cnt <= '0;
              r_state     <= c_HUNT;
            end
          end
          c_LOCKED: begin
            r_dout       <= w_win;
            r_dout_valid <= 1'b1;
            r_dout_idle  <= (w_win == LOCK_PATTERN) || (w_win == IDLE_PATTERN);
            // Only the lock pattern seen at a foreign offset counts toward a slip
            if (w_hit || !w_any) begin
              r_slip_run <= '0;
            end else if (r_slip_run + 4'd1 == c_SLIP_N) begin
              r_state     <= c_HUNT;
              r_locked    <= 1'b0;
              r_slip_cnt  <= w_slip_inc;
              r_slip_run  <= '0;
              r_match_cnt <= '0;
            end else begin
              r_slip_run  <= r_slip_run + 4'd1;
            end
          end
          default: r_state <= c_HUNT;
        endcase
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_idle  = r_dout_idle;
  assign bus.locked     = r_locked;
  assign bus.shift      = r_shift;
  assign bus.slip_cnt   = r_slip_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ldtu_rx_word_aligner.sv
// ============================================================================
// tb_ldtu_rx_word_aligner : vector table, directed sequences and random stream vs model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldtu_rx_word_aligner;

  localparam logic [31:0] LP = 32'h35555555;
  localparam logic [31:0] IP = 32'h5A5A5A5A;
  localparam logic [31:0] DW = 32'h12345678;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldtu_rx_word_aligner_if #(.NBITS(32)) bus ();

  ldtu_rx_word_aligner #(
    .NBITS(32), .LOCK_PATTERN(LP), .IDLE_PATTERN(IP), .LOCK_COUNT(4), .SLIP_COUNT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: aligned/confirming/searching behaviour from the word rules
  logic [31:0] m_prev, m_dout;
  int          m_mode, m_off, m_run, m_mis, m_slips;
  bit          m_dv, m_idle, m_lock;

  function automatic logic [31:0] win_of(input logic [63:0] c, input int k);
    return 32'((c >> (32 - k)) & 64'hFFFF_FFFF);
  endfunction

  task automatic model_step(input logic [31:0] din, input bit v, input bit rs, input bit r);
    logic [63:0] c;
    int first;
    bit hit;
    m_dv = 1'b0;
    if (r) begin
      m_prev = '0; m_mode = 0; m_off = 0; m_run = 0; m_mis = 0;
      m_dout = '0; m_idle = 1'b0; m_lock = 1'b0; m_slips = 0;
      return;
    end
    c = {m_prev, din};
    first = -1;
    for (int k = 31; k >= 0; k--) if (win_of(c, k) == LP) first = k;
    hit = (win_of(c, m_off) == LP);
    if (rs) begin
      if (m_mode == 2 && m_slips < 255) m_slips++;
      m_mode = 0; m_run = 0; m_mis = 0; m_lock = 1'b0;
    end else if (v) begin
      if (m_mode == 0) begin
        if (first >= 0) begin m_off = first; m_run = 1; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (hit) begin
          m_run++;
          if (m_run == 4) begin m_mode = 2; m_lock = 1'b1; end
        end else begin
          m_run = 0; m_mode = 0;
        end
      end else begin
        m_dout = win_of(c, m_off);
        m_dv   = 1'b1;
        m_idle = (m_dout == LP) || (m_dout == IP);
        if (!hit && first >= 0) begin
          m_mis++;
          if (m_mis == 3) begin
            m_mode = 0; m_lock = 1'b0; m_mis = 0; m_run = 0;
            if (m_slips < 255) m_slips++;
          end
        end else begin
          m_mis = 0;
        end
      end
    end
    if (v) m_prev = din;
  endtask

  task automatic step(input logic [31:0] din, input bit v, input bit rs, input bit r);
    bus.din = din; bus.din_valid = v; bus.resync = rs; rst = r;
    @(posedge clk);
    #1;
    model_step(din, v, rs, r);
    chk("model locked",     32'(bus.locked),     32'(m_lock));
    chk("model dout_valid", 32'(bus.dout_valid), 32'(m_dv));
    chk("model dout",       bus.dout,            m_dout);
    chk("model dout_idle",  32'(bus.dout_idle),  32'(m_idle));
    chk("model shift",      32'(bus.shift),      32'(m_off));
    chk("model slip_cnt",   32'(bus.slip_cnt),   32'(m_slips));
  endtask

  // Serial bit stream so offsets and slips are real bit delays
  bit q[$];
  task automatic push_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) q.push_back(w[i]);
  endtask
  task automatic pop_raw(output logic [31:0] w);
    for (int i = 31; i >= 0; i--) w[i] = q.pop_front();
  endtask
  task automatic send(input logic [31:0] aligned);
    logic [31:0] raw;
    push_word(aligned);
    pop_raw(raw);
    step(raw, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] din; bit v; bit rs; bit r;
    bit e_lock; bit e_dv; bit e_idle; logic [31:0] e_dout; logic [4:0] e_shift; logic [7:0] e_slip;
  } vec_t;
  vec_t tbl[12];

  initial begin
    bit seen, seen_idle, slip_seen;
    int slip_lock;
    logic [31:0] raw;
    int prior;

    bus.din = '0; bus.din_valid = 1'b0; bus.resync = 1'b0; rst = 1'b1;

    // Offset-0 lock: first window holds prev=0, output lags by one word
    tbl[0]  = '{LP, 0, 0, 1,  0, 0, 0, 32'h0, 5'd0, 8'd0};
    tbl[1]  = '{LP, 1, 0, 0,  0, 0, 0, 32'h0, 5'd0, 8'd0};
    tbl[2]  = '{LP, 1, 0, 0,  0, 0, 0, 32'h0, 5'd0, 8'd0};
    tbl[3]  = '{LP, 1, 0, 0,  0, 0, 0, 32'h0, 5'd0, 8'd0};
    tbl[4]  = '{LP, 1, 0, 0,  0, 0, 0, 32'h0, 5'd0, 8'd0};
    tbl[5]  = '{LP, 1, 0, 0,  1, 0, 0, 32'h0, 5'd0, 8'd0};
    tbl[6]  = '{LP, 1, 0, 0,  1, 1, 1, LP,    5'd0, 8'd0};
    tbl[7]  = '{IP, 1, 0, 0,  1, 1, 1, LP,    5'd0, 8'd0};
    tbl[8]  = '{DW, 1, 0, 0,  1, 1, 1, IP,    5'd0, 8'd0};
    tbl[9]  = '{LP, 1, 0, 0,  1, 1, 0, DW,    5'd0, 8'd0};
    tbl[10] = '{LP, 0, 0, 0,  1, 0, 0, DW,    5'd0, 8'd0};
    tbl[11] = '{LP, 1, 1, 0,  0, 0, 0, DW,    5'd0, 8'd1};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].din, tbl[i].v, tbl[i].rs, tbl[i].r);
      chk($sformatf("tbl[%0d] locked", i),   32'(bus.locked),     32'(tbl[i].e_lock));
      chk($sformatf("tbl[%0d] dvalid", i),   32'(bus.dout_valid), 32'(tbl[i].e_dv));
      chk($sformatf("tbl[%0d] idle", i),     32'(bus.dout_idle),  32'(tbl[i].e_idle));
      chk($sformatf("tbl[%0d] dout", i),     bus.dout,            tbl[i].e_dout);
      chk($sformatf("tbl[%0d] shift", i),    32'(bus.shift),      32'(tbl[i].e_shift));
      chk($sformatf("tbl[%0d] slip_cnt", i), 32'(bus.slip_cnt),   32'(tbl[i].e_slip));
    end

    // Stream delayed by 13 bits, lock words then a data word
    step('0, 1'b0, 1'b0, 1'b1);
    q.delete();
    for (int i = 0; i < 13; i++) q.push_back(1'b0);
    seen = 1'b0; seen_idle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(i < 6 ? LP : (i == 6 ? DW : IP));
      if (bus.dout_valid && bus.dout == DW) begin seen = 1'b1; seen_idle = bus.dout_idle; end
    end
    chk("off13 shift",     32'(bus.shift),  32'd13);
    chk("off13 locked",    32'(bus.locked), 32'd1);
    chk("off13 data seen", 32'(seen),       32'd1);
    chk("off13 data idle", 32'(seen_idle),  32'd0);

    // One-bit slip while locked at 13, then relock at 14
    q.push_back(1'b0);
    slip_seen = 1'b0; slip_lock = -1;
    for (int i = 0; i < 8; i++) begin
      send(LP);
      if (!slip_seen && bus.slip_cnt == 8'd1) begin slip_seen = 1'b1; slip_lock = int'(bus.locked); end
    end
    chk("slip counted",        32'(slip_seen), 32'd1);
    chk("slip unlocks",        32'(slip_lock), 32'd0);
    for (int i = 0; i < 4; i++) send(LP);
    chk("relock shift",        32'(bus.shift),  32'd14);
    chk("relock locked",       32'(bus.locked), 32'd1);
    for (int i = 0; i < 3; i++) send(IP);
    chk("idle word flagged",   32'(bus.dout_idle), 32'd1);
    chk("idle word value",     bus.dout, IP);

    // Corruption during verification, offset 0
    step('0, 1'b0, 1'b0, 1'b1);
    step(LP, 1'b1, 1'b0, 1'b0);
    step(LP, 1'b1, 1'b0, 1'b0);
    step(32'h0, 1'b1, 1'b0, 1'b0);
    step(LP, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(LP, 1'b1, 1'b0, 1'b0);
    chk("corrupt no lock yet", 32'(bus.locked), 32'd0);
    step(LP, 1'b1, 1'b0, 1'b0);
    chk("corrupt relock",      32'(bus.locked), 32'd1);

    // Valid toggling while locked
    for (int i = 0; i < 8; i++) step(i[0] ? $urandom : LP, !i[0], 1'b0, 1'b0);
    chk("toggle idle cycle dvalid", 32'(bus.dout_valid), 32'd0);
    step(LP, 1'b1, 1'b0, 1'b0);
    chk("toggle valid dvalid",      32'(bus.dout_valid), 32'd1);

    // Resync and reset while locked
    prior = m_slips;
    step(LP, 1'b1, 1'b1, 1'b0);
    chk("resync unlocks",  32'(bus.locked),   32'd0);
    chk("resync slip_cnt", 32'(bus.slip_cnt), 32'(prior + 1));
    chk("resync dvalid",   32'(bus.dout_valid), 32'd0);
    for (int i = 0; i < 5; i++) step(LP, 1'b1, 1'b0, 1'b0);
    chk("post resync lock", 32'(bus.locked), 32'd1);
    step(LP, 1'b1, 1'b0, 1'b1);
    chk("rst locked",   32'(bus.locked),   32'd0);
    chk("rst slip_cnt", 32'(bus.slip_cnt), 32'd0);
    chk("rst dout",     bus.dout,          32'd0);
    chk("rst shift",    32'(bus.shift),    32'd0);
    for (int i = 0; i < 5; i++) step(LP, 1'b1, 1'b0, 1'b0);
    chk("post rst lock", 32'(bus.locked), 32'd1);

    // Random bit streams with random offsets, slips, gaps, resyncs
    for (int seg = 0; seg < 40; seg++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(0, 31)); i++) q.push_back(bit'($urandom_range(0, 1)));
      for (int cyc = 0; cyc < 60; cyc++) begin
        int sel;
        logic [31:0] w;
        bit v, rs, r;
        sel = int'($urandom_range(0, 9));
        w   = (sel < 6) ? LP : ((sel < 8) ? IP : 32'($urandom));
        v   = ($urandom_range(0, 9) != 0);
        rs  = ($urandom_range(0, 99) == 0);
        r   = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 49) == 0) begin
          if (q.size() > 0 && $urandom_range(0, 1) == 1) void'(q.pop_front());
          else q.push_back(bit'($urandom_range(0, 1)));
        end
        if (v) begin
          push_word(w);
          pop_raw(raw);
        end else begin
          raw = 32'($urandom);
        end
        step(raw, v, rs, r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
